// File: rtl/bg_pkg.sv
// Shared types and defaults for the background scroll sequencer and its helpers.
package bg_pkg;

  typedef enum logic [2:0] {IDLE, HOR, C1, C2, DONE} bg_state_t;

  typedef logic [9:0] coord_t;

  localparam coord_t SCREEN_W_DEFAULT = 10'd640;

endpackage

// File: rtl/background_scroll_ctrl_wrap_dec.sv
// Combinational decrement of a coordinate that wraps from 0 to modulus-1.
module wrap_dec (
  input  logic [9:0] value,
  input  logic [9:0] modulus,
  output logic [9:0] result
);

  assign result = (value == 10'd0) ? (modulus - 10'd1) : (value - 10'd1);

endmodule

// File: rtl/background_scroll_ctrl.sv
// Per-frame background animation sequencer: advances horizon phase and cloud
// positions during vertical blanking and holds them for the active frame.
module background_scroll_ctrl
  import bg_pkg::*;
#(
  parameter logic [9:0] SCREEN_W       = SCREEN_W_DEFAULT,
  parameter logic [9:0] CLOUD1_X0      = 10'd10,
  parameter logic [9:0] CLOUD2_X0      = 10'd100,
  parameter logic [9:0] HORIZON_PERIOD = 10'd64,
  parameter logic [2:0] CLOUD_DIV      = 3'd4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_start,
  input  logic       enable,
  input  logic [2:0] speed,
  output logic [9:0] horizon_phase,
  output logic [9:0] cloud1_x,
  output logic [9:0] cloud2_x,
  output logic       busy,
  output logic       update_done,
  output logic       overrun
);

  bg_state_t  state_reg, state_next;
  coord_t     phase_reg, phase_next;
  coord_t     cloud1_reg, cloud1_next;
  coord_t     cloud2_reg, cloud2_next;
  logic [2:0] frame_cnt_reg, frame_cnt_next;
  logic       speed_nz_reg, speed_nz_next;
  logic       busy_reg, busy_next;
  logic       done_reg, done_next;
  logic       overrun_reg, overrun_next;

  logic       cloud_tick;
  logic [10:0] phase_sum;
  logic [10:0] phase_wrapped;
  coord_t     cloud1_dec, cloud2_dec;

  assign cloud_tick    = (frame_cnt_reg == (CLOUD_DIV - 3'd1));
  assign phase_sum     = {1'b0, phase_reg} + {8'd0, speed};
  assign phase_wrapped = phase_sum - {1'b0, HORIZON_PERIOD};

  wrap_dec u_dec_cloud1 (
    .value   (cloud1_reg),
    .modulus (SCREEN_W),
    .result  (cloud1_dec)
  );

  wrap_dec u_dec_cloud2 (
    .value   (cloud2_reg),
    .modulus (SCREEN_W),
    .result  (cloud2_dec)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      phase_reg     <= '0;
      cloud1_reg    <= CLOUD1_X0;
      cloud2_reg    <= CLOUD2_X0;
      frame_cnt_reg <= '0;
      speed_nz_reg  <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      phase_reg     <= phase_next;
      cloud1_reg    <= cloud1_next;
      cloud2_reg    <= cloud2_next;
      frame_cnt_reg <= frame_cnt_next;
      speed_nz_reg  <= speed_nz_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
      overrun_reg   <= overrun_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (frame_start && enable) state_next = HOR;
      HOR:     state_next = C1;
      C1:      state_next = C2;
      C2:      state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Speed is captured in HOR so the cloud steps of this frame use the same value.
  always_comb begin
    phase_next     = phase_reg;
    cloud1_next    = cloud1_reg;
    cloud2_next    = cloud2_reg;
    frame_cnt_next = frame_cnt_reg;
    speed_nz_next  = speed_nz_reg;
    case (state_reg)
      HOR: begin
        phase_next    = (phase_sum >= {1'b0, HORIZON_PERIOD}) ? phase_wrapped[9:0]
                                                              : phase_sum[9:0];
        speed_nz_next = (speed != 3'd0);
      end
      C1: begin
        if (cloud_tick && speed_nz_reg) cloud1_next = cloud1_dec;
      end
      C2: begin
        if (cloud_tick && speed_nz_reg) cloud2_next = cloud2_dec;
        frame_cnt_next = cloud_tick ? 3'd0 : (frame_cnt_reg + 3'd1);
      end
      default: ;
    endcase
    busy_next    = (state_next != IDLE);
    done_next    = (state_next == DONE);
    overrun_next = overrun_reg | (frame_start && (state_reg != IDLE));
  end

  assign horizon_phase = phase_reg;
  assign cloud1_x      = cloud1_reg;
  assign cloud2_x      = cloud2_reg;
  assign busy          = busy_reg;
  assign update_done   = done_reg;
  assign overrun       = overrun_reg;

endmodule

// File: tb/tb_background_scroll_ctrl.sv
// Bench for background_scroll_ctrl: a frame-timeline model checked every cycle
// against two instances (default parameters and a fast-cloud variant).
module tb_background_scroll_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_start;
  logic       enable;
  logic [2:0] speed;
  logic [9:0] ph [2];
  logic [9:0] c1 [2];
  logic [9:0] c2 [2];
  logic       bz [2];
  logic       dn [2];
  logic       ov [2];

  int compared   = 0;
  int mismatched = 0;
  bit checking   = 0;
  int done_cnt_a = 0;
  int busy_cnt_a = 0;

  always #5 clk = ~clk;

  background_scroll_ctrl dut_a (
    .clk(clk), .reset(reset), .frame_start(frame_start), .enable(enable), .speed(speed),
    .horizon_phase(ph[0]), .cloud1_x(c1[0]), .cloud2_x(c2[0]),
    .busy(bz[0]), .update_done(dn[0]), .overrun(ov[0])
  );

  background_scroll_ctrl #(.CLOUD_DIV(3'd1), .CLOUD1_X0(10'd0)) dut_b (
    .clk(clk), .reset(reset), .frame_start(frame_start), .enable(enable), .speed(speed),
    .horizon_phase(ph[1]), .cloud1_x(c1[1]), .cloud2_x(c2[1]),
    .busy(bz[1]), .update_done(dn[1]), .overrun(ov[1])
  );

  // Model: age counts cycles since an accepted frame_start (0 = idle).
  int div_p [2] = '{4, 1};
  int x1_0  [2] = '{10, 0};
  int x2_0  [2] = '{100, 100};
  int m_phase [2];
  int m_c1 [2];
  int m_c2 [2];
  int m_cnt [2];
  int m_age [2];
  int m_spd [2];
  int m_ovr [2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_phase[i] = 0; m_c1[i] = x1_0[i]; m_c2[i] = x2_0[i];
        m_cnt[i] = 0; m_age[i] = 0; m_spd[i] = 0; m_ovr[i] = 0;
      end else begin
        if (m_age[i] != 0 && frame_start) m_ovr[i] = 1;
        case (m_age[i])
          0: if (frame_start && enable) m_age[i] = 1;
          1: begin
            m_spd[i] = int'(speed);
            m_phase[i] = (m_phase[i] + m_spd[i]) % 64;
            m_age[i] = 2;
          end
          2: begin
            if (m_cnt[i] == div_p[i] - 1 && m_spd[i] != 0) m_c1[i] = (m_c1[i] + 639) % 640;
            m_age[i] = 3;
          end
          3: begin
            if (m_cnt[i] == div_p[i] - 1 && m_spd[i] != 0) m_c2[i] = (m_c2[i] + 639) % 640;
            m_cnt[i] = (m_cnt[i] == div_p[i] - 1) ? 0 : m_cnt[i] + 1;
            m_age[i] = 4;
          end
          default: m_age[i] = 0;
        endcase
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checking) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("dut%0d_phase", i), int'(ph[i]), m_phase[i]);
        check($sformatf("dut%0d_cloud1", i), int'(c1[i]), m_c1[i]);
        check($sformatf("dut%0d_cloud2", i), int'(c2[i]), m_c2[i]);
        check($sformatf("dut%0d_busy", i), int'(bz[i]), (m_age[i] != 0) ? 1 : 0);
        check($sformatf("dut%0d_done", i), int'(dn[i]), (m_age[i] == 4) ? 1 : 0);
        check($sformatf("dut%0d_overrun", i), int'(ov[i]), m_ovr[i]);
      end
      if (dn[0] === 1'b1) done_cnt_a++;
      if (bz[0] === 1'b1) busy_cnt_a++;
    end
  end

  task automatic frame();
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  int d0, b0;

  initial begin
    reset = 1'b1; frame_start = 1'b1; enable = 1'b1; speed = 3'd5;
    repeat (2) @(negedge clk);
    checking = 1;
    reset = 1'b0; frame_start = 1'b0;
    @(negedge clk);
    $display("reset: phase=%0d c1=%0d c2=%0d busy=%0b", ph[0], c1[0], c2[0], bz[0]);
    check("rst_cloud1", int'(c1[0]), 10);
    check("rst_cloud2", int'(c2[0]), 100);
    check("rst_phase", int'(ph[0]), 0);
    check("rst_busy", int'(bz[0]), 0);
    check("rst_done", int'(dn[0]), 0);
    check("rst_overrun", int'(ov[0]), 0);

    frame();
    $display("wrap frame: b.c1=%0d a.c1=%0d", c1[1], c1[0]);
    check("wrap_b_cloud1", int'(c1[1]), 639);
    check("wrap_b_cloud2", int'(c2[1]), 99);
    check("wrap_a_cloud1", int'(c1[0]), 10);

    do_reset();
    for (int f = 0; f < 13; f++) frame();
    $display("13 frames speed5: phase=%0d c1=%0d c2=%0d", ph[0], c1[0], c2[0]);
    check("cad_phase", int'(ph[0]), 1);
    check("cad_cloud1", int'(c1[0]), 7);
    check("cad_cloud2", int'(c2[0]), 97);

    speed = 3'd0;
    d0 = done_cnt_a;
    for (int f = 0; f < 8; f++) frame();
    $display("8 frames speed0: phase=%0d c1=%0d c2=%0d dones=%0d", ph[0], c1[0], c2[0], done_cnt_a - d0);
    check("spd0_dones", done_cnt_a - d0, 8);
    check("spd0_phase", int'(ph[0]), 1);
    check("spd0_cloud1", int'(c1[0]), 7);

    speed = 3'd3;
    d0 = done_cnt_a;
    frame_start = 1'b1; @(negedge clk);
    frame_start = 1'b0; @(negedge clk);
    frame_start = 1'b1; @(negedge clk);
    frame_start = 1'b0;
    repeat (6) @(negedge clk);
    $display("overrun: ov=%0b dones=%0d phase=%0d", ov[0], done_cnt_a - d0, ph[0]);
    check("ovr_flag", int'(ov[0]), 1);
    check("ovr_dones", done_cnt_a - d0, 1);
    check("ovr_phase", int'(ph[0]), 4);

    enable = 1'b0;
    b0 = busy_cnt_a; d0 = done_cnt_a;
    frame(); frame();
    $display("paused: busy_cycles=%0d dones=%0d ov=%0b", busy_cnt_a - b0, done_cnt_a - d0, ov[0]);
    check("pause_busy", busy_cnt_a - b0, 0);
    check("pause_dones", done_cnt_a - d0, 0);
    check("pause_phase", int'(ph[0]), 4);
    check("pause_ovr_sticky", int'(ov[0]), 1);

    enable = 1'b1; speed = 3'd5;
    d0 = done_cnt_a;
    frame_start = 1'b1; @(negedge clk);
    frame_start = 1'b0; @(negedge clk);
    reset = 1'b1; @(negedge clk);
    reset = 1'b0;
    check("midrst_cloud1", int'(c1[0]), 10);
    @(negedge clk);
    check("midrst_busy", int'(bz[0]), 0);
    repeat (5) @(negedge clk);
    $display("mid-seq reset: c1=%0d phase=%0d dones=%0d", c1[0], ph[0], done_cnt_a - d0);
    check("midrst_dones", done_cnt_a - d0, 0);
    check("midrst_phase", int'(ph[0]), 0);

    checking = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/background_scroll_ctrl.md
# background_scroll_ctrl

Frame-rate sequencer that animates the game background. Once per video frame, during vertical blanking, it advances the horizon scroll phase and the two cloud X positions, then holds them stable for the whole active frame. Its outputs feed the combinational background renderer, which uses them in place of its fixed cloud and horizon positions. It sits between the VGA timing generator (source of `frame_start`) and the background renderer.

## Interface
Parameters:
- `SCREEN_W`, 10'd640, visible width; cloud X wraps modulo this value.
- `CLOUD1_X0`, 10'd10, reset X of cloud 1.
- `CLOUD2_X0`, 10'd100, reset X of cloud 2.
- `HORIZON_PERIOD`, 10'd64, modulus of the horizon scroll phase.
- `CLOUD_DIV`, 3'd4, clouds move once every CLOUD_DIV frames (parallax). Legal range is 1..7.

Ports:
- `clk`  in  1  pixel clock; single clock domain.
- `reset`  in  1  synchronous, active-high.
- `frame_start`  in  1  one-cycle pulse at start of vertical blanking.
- `enable`  in  1  game running; when low, frames are ignored and positions hold.
- `speed`  in  3  horizon pixels advanced per frame (0..7).
- `horizon_phase`  out  10  horizon pattern offset, 0..HORIZON_PERIOD-1.
- `cloud1_x`  out  10  cloud 1 left edge, 0..SCREEN_W-1.
- `cloud2_x`  out  10  cloud 2 left edge, 0..SCREEN_W-1.
- `busy`  out  1  high while an update sequence is in progress.
- `update_done`  out  1  one-cycle pulse when the sequence completes.
- `overrun`  out  1  sticky flag: a `frame_start` arrived while busy.

## Operation
- FSM states are IDLE, HOR, C1, C2, DONE. All outputs are registered.
- **IDLE:** if `frame_start & enable`, go to HOR. Otherwise stay in IDLE.
- **HOR:** set `horizon_phase <= (horizon_phase + speed) mod HORIZON_PERIOD`. Compute in 11 bits and subtract HORIZON_PERIOD once if the sum is ≥ it. Go to C1.
- **C1:** if `cloud_tick` and `speed != 0`, move cloud 1 left one pixel:
  - `cloud1_x <= (cloud1_x == 0) ? SCREEN_W-1 : cloud1_x-1`.
  - Go to C2.
- **C2:** move cloud 2 by the same rule as C1. Then update the frame counter:
  - `frame_cnt <= cloud_tick ? 0 : frame_cnt+1`.
  - Go to DONE.
- **DONE:** `update_done = 1`. Go to IDLE.
- `cloud_tick = (frame_cnt == CLOUD_DIV-1)`; `frame_cnt` is 3 bits.
- `busy = (state != IDLE)`.
- `frame_start` while not in IDLE is ignored and sets `overrun`. Only `reset` clears `overrun`.
- With `enable` low, no sequence starts and `frame_cnt` holds. A sequence already running completes normally.
- With `speed == 0`, the sequence still runs and `update_done` still pulses. Positions are unchanged, but `frame_cnt` still advances.
- `speed` is sampled in HOR only. Changes during C1/C2/DONE take effect on the next frame.

## Timing
- Reset values: state IDLE, `horizon_phase` 0, `cloud1_x` CLOUD1_X0, `cloud2_x` CLOUD2_X0, `frame_cnt` 0, `busy` 0, `update_done` 0, `overrun` 0.
- Cycle-level sequence, with `frame_start` sampled at edge k:
  - `busy` is high from edge k until edge k+4.
  - `horizon_phase` is valid after edge k+1.
  - `cloud1_x` is valid after edge k+2.
  - `cloud2_x` is valid after edge k+3.
  - `update_done` is high for exactly the cycle between edges k+3 and k+4.
- Sequence length is 4 cycles, far inside any blanking interval. Outputs never change outside the sequence.
- Reset asserted mid-sequence: all registers take their reset values at the next edge, partial updates are discarded, and `update_done` does not pulse.
- `frame_start` coincident with `reset`: reset wins and no sequence starts.

## Structure
- Shared package `bg_pkg`:
  - `typedef enum logic [2:0] {IDLE, HOR, C1, C2, DONE} bg_state_t`.
  - `typedef logic [9:0] coord_t`.
  - The default SCREEN_W constant.
- One sub-module, `wrap_dec`: a combinational decrement-with-wrap of a `coord_t` against a modulus. It is instantiated twice, once per cloud.

## Test plan
- **Reset values:** after reset, `cloud1_x`=10, `cloud2_x`=100, `horizon_phase`=0, and `busy`, `update_done`, `overrun` are all 0.
- **Horizon and cloud cadence:** `speed`=5, 13 frames -> `horizon_phase` = 65 mod 64 = 1. Clouds move on frames 4, 8, 12 only, so `cloud1_x`=7 and `cloud2_x`=97.
- **Cloud wrap:** `cloud1_x` at 0 with `CLOUD_DIV`=1, one frame -> `cloud1_x`=639.
- **Speed zero:** `speed`=0 for 8 frames -> positions unchanged and `update_done` pulses 8 times.
- **Overrun and pause:**
  - `frame_start` at k and again at k+2 -> a single sequence runs and `overrun`=1 and stays set.
  - `enable`=0 with `frame_start` -> `busy` stays 0 and no outputs change.
- **Reset mid-sequence:** `reset` at edge k+2 -> `cloud1_x`=10, state is IDLE at k+3, and no `update_done` pulse occurs.
